// File: rtl/branch_stall_ctrl.sv
// ---------------------------------------------------------------------------
// branch_stall_ctrl
//
// Control-side driver for the program counter. Decodes the fetched
// instruction, produces the jump enable and the jump target (read from a
// loadable 16-entry target LUT), and sequences the multi-cycle stall window
// that the PC needs for memory operations.
//
// Optional feature macro: BRANCH_FLUSH_EN
//   defined   : a taken branch (Jen & Zero) inserts one FLUSH cycle in which
//               Bubble is high and Jen is held low.
//   undefined : no FLUSH state, Bubble is tied low, a taken branch leaves the
//               controller in IDLE.
//
// Parameters
//   STALL_CYC  cycles StallCtr is held high per memory op (legal 2..15)
//   OP_BZ      opcode (Instr[8:5]) of branch-if-zero
//   OP_LD      opcode of load  (multi-cycle)
//   OP_ST      opcode of store (multi-cycle)
//
// Ports
//   Clk       in   1  clock, all state updates on posedge
//   Reset     in   1  synchronous, active-high
//   Instr     in   9  current instruction; [8:5] opcode, [3:0] LUT index
//   Zero      in   1  ALU zero flag (only used for flush tracking)
//   LutWe     in   1  target LUT write strobe
//   LutAddr   in   4  target LUT write index
//   LutData   in   8  target LUT write data
//   Jen       out  1  jump enable to PC (PC jumps when Jen & Zero)
//   Jump      out  8  jump target = lut[Instr[3:0]]
//   StallCtr  out  1  stall window to PC, high STALL_CYC cycles per mem op
//   Bubble    out  1  downstream must treat the current Instr as a NOP
//   DbgState  out  2  current FSM state (0 IDLE, 1 STALL, 2 RELEASE, 3 FLUSH)
//   DbgCnt    out  4  current stall down-counter
//
// Handshake: there is no valid/ready pair; every input is sampled on each
// rising edge of Clk and the combinational outputs (Jen, Jump) follow Instr
// within the same cycle, while StallCtr/Bubble follow the registered state.
// ---------------------------------------------------------------------------
module branch_stall_ctrl #(
    parameter int unsigned STALL_CYC = 4,
    parameter logic [3:0]  OP_BZ     = 4'hE,
    parameter logic [3:0]  OP_LD     = 4'h8,
    parameter logic [3:0]  OP_ST     = 4'h9
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [8:0] Instr,
    input  logic       Zero,
    input  logic       LutWe,
    input  logic [3:0] LutAddr,
    input  logic [7:0] LutData,
    output logic       Jen,
    output logic [7:0] Jump,
    output logic       StallCtr,
    output logic       Bubble,
    output logic [1:0] DbgState,
    output logic [3:0] DbgCnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STALL   = 2'd1,
        S_RELEASE = 2'd2
`ifdef BRANCH_FLUSH_EN
        ,
        S_FLUSH   = 2'd3
`endif
    } state_t;

    // Counter preload: STALL_CYC-1 down to 0 gives exactly STALL_CYC cycles.
    localparam logic [3:0] STALL_LOAD = 4'(STALL_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [7:0] lut [16];

    logic [3:0] opcode;
    logic [3:0] lut_idx;
    logic       is_mem;
    logic       is_bz;

    assign opcode  = Instr[8:5];
    assign lut_idx = Instr[3:0];
    assign is_mem  = (opcode == OP_LD) || (opcode == OP_ST);
    assign is_bz   = (opcode == OP_BZ);

    // Instr[4] carries no meaning here; Zero is unused when flushing is off.
    logic unused_ok;
    assign unused_ok = &{1'b0, Instr[4], Zero};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Target LUT: synchronous write, combinational read. A write and a read
    // of the same entry in one cycle returns the old contents that cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                lut[i] <= 8'h00;
            end
        end else if (LutWe) begin
            lut[LutAddr] <= LutData;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (is_mem) begin
                    state_nxt = S_STALL;
                    cnt_nxt   = STALL_LOAD;
                end
`ifdef BRANCH_FLUSH_EN
                else if (Jen && Zero) begin
                    state_nxt = S_FLUSH;
                end
`endif
            end
            S_STALL: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RELEASE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            // One dead cycle so a mem op still sitting on Instr does not
            // immediately retrigger another stall window.
            S_RELEASE: begin
                state_nxt = S_IDLE;
            end
`ifdef BRANCH_FLUSH_EN
            S_FLUSH: begin
                state_nxt = S_IDLE;
            end
`endif
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs. Branches seen outside IDLE are dropped (Jen low).
    // -----------------------------------------------------------------------
    assign Jen      = is_bz && (state == S_IDLE) && !Reset;
    assign Jump     = Reset ? 8'h00 : lut[lut_idx];
    assign StallCtr = (state == S_STALL);
`ifdef BRANCH_FLUSH_EN
    assign Bubble   = (state == S_FLUSH);
`else
    assign Bubble   = 1'b0;
`endif
    assign DbgState = state;
    assign DbgCnt   = cnt;

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for branch_stall_ctrl. The driver applies one directed vector per
// cycle and pushes the hand-computed output vector into exp_q; the monitor
// pops on the falling edge and compares. Works with or without
// BRANCH_FLUSH_EN defined.
// ---------------------------------------------------------------------------
module tb_branch_stall_ctrl;

    localparam int W = 17;  // {Jen, Jump[7:0], StallCtr, Bubble, State[1:0], Cnt[3:0]}

`ifdef BRANCH_FLUSH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    localparam logic [3:0] OP0 = 4'h0;
    localparam logic [3:0] BZ  = 4'hE;
    localparam logic [3:0] LD  = 4'h8;
    localparam logic [3:0] ST  = 4'h9;

    localparam logic [1:0] I_ = 2'd0;  // IDLE
    localparam logic [1:0] S_ = 2'd1;  // STALL
    localparam logic [1:0] R_ = 2'd2;  // RELEASE
    localparam logic [1:0] F_ = 2'd3;  // FLUSH

    // Clock / reset
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [8:0] Instr = 9'd0;
    logic       Zero = 1'b0;
    logic       LutWe = 1'b0;
    logic [3:0] LutAddr = 4'd0;
    logic [7:0] LutData = 8'd0;
    logic       Jen;
    logic [7:0] Jump;
    logic       StallCtr;
    logic       Bubble;
    logic [1:0] DbgState;
    logic [3:0] DbgCnt;

    always #5 Clk = ~Clk;

    branch_stall_ctrl #(
        .STALL_CYC (4),
        .OP_BZ     (4'hE),
        .OP_LD     (4'h8),
        .OP_ST     (4'h9)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Instr    (Instr),
        .Zero     (Zero),
        .LutWe    (LutWe),
        .LutAddr  (LutAddr),
        .LutData  (LutData),
        .Jen      (Jen),
        .Jump     (Jump),
        .StallCtr (StallCtr),
        .Bubble   (Bubble),
        .DbgState (DbgState),
        .DbgCnt   (DbgCnt)
    );

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] g;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {Jen, Jump, StallCtr, Bubble, DbgState, DbgCnt};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got jen=%b jump=%h stall=%b bub=%b st=%0d cnt=%0d, exp jen=%b jump=%h stall=%b bub=%b st=%0d cnt=%0d",
                         nm, g[16], g[15:8], g[7], g[6], g[5:4], g[3:0],
                         e[16], e[15:8], e[7], e[6], e[5:4], e[3:0]);
            end
        end
    end

    // Driver: one vector per cycle, applied #1 after the rising edge.
    task automatic step(input string nm, input logic rst,
                        input logic [3:0] op, input logic [3:0] idx, input logic z,
                        input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic e_jen, input logic [7:0] e_jump,
                        input logic e_stall, input logic e_bub,
                        input logic [1:0] e_st, input logic [3:0] e_cnt);
        @(posedge Clk);
        #1;
        Reset   = rst;
        Instr   = {op, 1'b0, idx};
        Zero    = z;
        LutWe   = we;
        LutAddr = wa;
        LutData = wd;
        exp_q.push_back({e_jen, e_jump, e_stall, e_bub, e_st, e_cnt});
        name_q.push_back(nm);
    endtask

    initial begin
        // 1: reset for two cycles; Jen/Jump forced low even with BZ/LD on Instr
        step("rst_c1", 1, BZ, 4'd3, 1, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, I_, 4'd0);
        step("rst_c2", 1, LD, 4'd3, 1, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, I_, 4'd0);
        for (int i = 0; i < 16; i++) begin
            step($sformatf("lut_zero_%0d", i), 0, OP0, 4'(i), 0, 0, 4'd0, 8'h00,
                 0, 8'h00, 0, 0, I_, 4'd0);
        end

        // 2 + 6: LUT load then taken / not-taken branch
        step("lut_wr3",        0, OP0, 4'd3, 0, 1, 4'd3, 8'h5A, 0, 8'h00, 0, 0, I_, 4'd0);
        step("bz_taken",       0, BZ,  4'd3, 1, 0, 4'd0, 8'h00, 1, 8'h5A, 0, 0, I_, 4'd0);
        step("bz_after_taken", 0, BZ,  4'd3, 0, 0, 4'd0, 8'h00, !FL, 8'h5A, 0, FL, FL ? F_ : I_, 4'd0);
        step("bz_not_taken",   0, BZ,  4'd3, 0, 0, 4'd0, 8'h00, 1, 8'h5A, 0, 0, I_, 4'd0);
        step("no_bubble",      0, OP0, 4'd3, 0, 0, 4'd0, 8'h00, 0, 8'h5A, 0, 0, I_, 4'd0);

        // 3: OP_LD held -> 4 stall cycles, 1 release, retrigger from IDLE;
        //    branches during STALL/RELEASE are dropped
        step("ld_decode",   0, LD,  4'd5, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, I_, 4'd0);
        step("ld_stall1",   0, LD,  4'd5, 0, 0, 4'd0, 8'h00, 0, 8'h00, 1, 0, S_, 4'd3);
        step("ld_stall2",   0, LD,  4'd5, 0, 0, 4'd0, 8'h00, 0, 8'h00, 1, 0, S_, 4'd2);
        step("ld_stall3",   0, LD,  4'd5, 0, 0, 4'd0, 8'h00, 0, 8'h00, 1, 0, S_, 4'd1);
        step("ld_stall4",   0, LD,  4'd5, 0, 0, 4'd0, 8'h00, 0, 8'h00, 1, 0, S_, 4'd0);
        step("ld_release",  0, LD,  4'd5, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, R_, 4'd0);
        step("ld_redecode", 0, LD,  4'd5, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, I_, 4'd0);
        step("ld2_stall1",  0, LD,  4'd5, 0, 0, 4'd0, 8'h00, 0, 8'h00, 1, 0, S_, 4'd3);
        step("bz_in_stall2",0, BZ,  4'd3, 1, 0, 4'd0, 8'h00, 0, 8'h5A, 1, 0, S_, 4'd2);
        step("bz_in_stall3",0, BZ,  4'd3, 1, 0, 4'd0, 8'h00, 0, 8'h5A, 1, 0, S_, 4'd1);
        step("bz_in_stall4",0, BZ,  4'd3, 1, 0, 4'd0, 8'h00, 0, 8'h5A, 1, 0, S_, 4'd0);
        step("bz_in_rel",   0, BZ,  4'd3, 1, 0, 4'd0, 8'h00, 0, 8'h5A, 0, 0, R_, 4'd0);
        step("idle_after",  0, OP0, 4'd0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, I_, 4'd0);

        // 4: OP_ST, Reset on the 2nd stall cycle aborts the window (and clears LUT)
        step("st_decode",      0, ST,  4'd0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, I_, 4'd0);
        step("st_stall1",      0, OP0, 4'd0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 1, 0, S_, 4'd3);
        step("st_reset_mid",   1, BZ,  4'd3, 1, 0, 4'd0, 8'h00, 0, 8'h00, 1, 0, S_, 4'd2);
        step("st_after_reset", 0, OP0, 4'd3, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, I_, 4'd0);

        // 5: write/read same index in one cycle -> old value, new value next cycle
        step("lut7_wr",   0, BZ,  4'd7, 0, 1, 4'd7, 8'h11, 1, 8'h00, 0, 0, I_, 4'd0);
        step("lut7_new",  0, BZ,  4'd7, 0, 0, 4'd0, 8'h00, 1, 8'h11, 0, 0, I_, 4'd0);
        step("lut7_wr2",  0, BZ,  4'd7, 0, 1, 4'd7, 8'h22, 1, 8'h11, 0, 0, I_, 4'd0);
        step("lut7_new2", 0, BZ,  4'd7, 0, 0, 4'd0, 8'h00, 1, 8'h22, 0, 0, I_, 4'd0);
        step("lutF_wr",   0, BZ,  4'd7, 0, 1, 4'd15, 8'hC3, 1, 8'h22, 0, 0, I_, 4'd0);
        step("lutF_rd",   0, OP0, 4'd15, 0, 0, 4'd0, 8'h00, 0, 8'hC3, 0, 0, I_, 4'd0);

        // Let the monitor drain, bounded to a few cycles.
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: got %0d pending, exp 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
